pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, meaning pipeline depth; stage 0 = IF, stage NUM_STAGES-1 = WB; legal range 3..8.
REQ-002 SHALL have parameter NUM_STALL_SRC, default 2, meaning number of stall requesters (index 0 = instruction cache, 1 = data cache); higher index = higher priority; legal range 1..4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall_req  input  NUM_STALL_SRC  per-source stall request, level, held until refill done.
REQ-006 SHALL have port insert_nop  input  1  load-use hazard from hazard detection.
REQ-007 SHALL have port branch_redo  input  1  mispredict, squash instruction leaving IF.
REQ-008 SHALL have port stall  output  1  global freeze of all pipeline registers.
REQ-009 SHALL have port pc_en  output  1  IF/PC advance enable.
REQ-010 SHALL have port bubble_id  output  1  load NOP into IF:ID register.
REQ-011 SHALL have port stage_valid  output  NUM_STAGES  per-stage valid bits.
REQ-012 SHALL have port wr_gate  output  NUM_STALL_SRC  per-source cache write-enable pass; 0 forces CACHE_NO_WR.
REQ-013 SHALL have port stall_owner  output  NUM_STALL_SRC  one-hot registered owner, zero when not stalled.
REQ-014 SHALL have port stall_cycles  output  32  saturating count of stalled cycles.
REQ-015 SHALL have port instret  output  32  wrapping count of retired valid instructions.

Function
REQ-016 SHALL implement FSM states RUN and STALL with registered owner.
REQ-017 SHALL compute grant_c combinationally: registered owner if state==STALL and stall_req[owner]=1, else one-hot highest-index asserted stall_req bit, else zero.
REQ-018 SHALL transition RUN->STALL when any stall_req=1, loading owner<=grant_c.
REQ-019 SHALL in STALL stay with same owner while stall_req[owner]=1; when it drops and another request is pending, load the new grant_c owner with no RUN cycle; when none pending, return to RUN and clear owner.
REQ-020 SHALL drive stall = OR of stall_req, combinationally (freeze in the same cycle the miss is raised).
REQ-021 SHALL drive wr_gate[k] = 1 when no stall_req is set, else grant_c[k].
REQ-022 SHALL drive pc_en = ~stall & ~insert_nop and bubble_id = ~stall & (insert_nop | branch_redo).
REQ-023 SHALL treat stage_valid[0] as constant 1 while out of reset; when stall=0 update valid[1] <= ~(insert_nop|branch_redo) and valid[i] <= valid[i-1] for i>=2; when stall=1 hold all.
REQ-024 SHALL give stall precedence over insert_nop and branch_redo: no bubble, no PC move, hazard re-evaluated next unstalled cycle.
REQ-025 SHALL increment stall_cycles each cycle stall=1, saturating at 0xFFFF_FFFF.
REQ-026 SHALL increment instret when stall=0 and stage_valid[NUM_STAGES-1]=1, wrapping to 0 after 0xFFFF_FFFF.

Reset
REQ-027 SHALL on reset_n=0 asynchronously set state=RUN, owner=0, stage_valid[NUM_STAGES-1:1]=0, stall_cycles=0, instret=0.
REQ-028 SHALL on reset asserted mid-stall abandon ownership immediately; after release stall follows stall_req only.

Structure
REQ-029 SHALL place PipeCtrlState enum (PIPE_RUN, PIPE_STALL) and stage index constants STAGE_IF..STAGE_WB in package_project_typedefs.
REQ-030 SHALL instantiate one sub-module stall_arbiter (parametrised NUM_STALL_SRC, fixed-priority one-hot grant with owner hold) producing grant_c.

Verification
REQ-031 SHALL cover: reset, no stalls, 10 cycles -> stage_valid 5'b11111 from cycle 4, instret=6 after cycle 10.
REQ-032 SHALL cover: stall_req=2'b01 for 3 cycles -> stall=1 same cycles, owner=01, wr_gate=01, stall_cycles=3, stage_valid unchanged.
REQ-033 SHALL cover: stall_req=2'b11 same cycle, drop bit1 after 2 cycles -> owner 10 then 01 with no RUN gap, wr_gate tracks owner.
REQ-034 SHALL cover: insert_nop=1 one cycle, no stall -> pc_en=0, bubble_id=1, valid[1]=0 next cycle, hole reaches WB 3 cycles later.
REQ-035 SHALL cover: insert_nop=1 with stall_req=01 -> bubble_id=0, pc_en=0, valid held; bubble inserted first cycle after release if insert_nop still high.
REQ-036 SHALL cover: reset_n low during STALL with owner=10 -> owner=0, state RUN, counters 0 without clock edge.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared pipeline-control types: controller FSM state and classic 5-stage indices.
package package_project_typedefs;

  typedef enum logic {
    PIPE_RUN   = 1'b0,
    PIPE_STALL = 1'b1
  } PipeCtrlState;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

endpackage

// File: rtl/pipeline_controller_stall_arbiter.sv
// Fixed-priority stall arbiter: highest index wins, but a current owner keeps
// the grant for as long as it keeps requesting.
module stall_arbiter
  import package_project_typedefs::*;
#(
  parameter int NUM_STALL_SRC = 2
) (
  input  logic [NUM_STALL_SRC-1:0] req_i,
  input  logic [NUM_STALL_SRC-1:0] owner_i,
  input  PipeCtrlState             state_i,
  output logic [NUM_STALL_SRC-1:0] grant_o
);

  logic [NUM_STALL_SRC-1:0] prio_c;

  // Ascending scan so the last (highest) asserted bit overwrites lower ones.
  always_comb begin
    prio_c = '0;
    for (int k = 0; k < NUM_STALL_SRC; k++) begin
      if (req_i[k]) begin
        prio_c    = '0;
        prio_c[k] = 1'b1;
      end
    end
  end

  assign grant_o = (state_i == PIPE_STALL && |(req_i & owner_i)) ? owner_i : prio_c;

endmodule

// File: rtl/pipeline_controller.sv
// In-order pipeline controller: global freeze on cache misses, load-use and
// mispredict bubbles, per-stage valid tracking and perf counters.
module pipeline_controller
  import package_project_typedefs::*;
#(
  parameter int NUM_STAGES    = 5,
  parameter int NUM_STALL_SRC = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_STALL_SRC-1:0] stall_req,
  input  logic                     insert_nop,
  input  logic                     branch_redo,
  output logic                     stall,
  output logic                     pc_en,
  output logic                     bubble_id,
  output logic [NUM_STAGES-1:0]    stage_valid,
  output logic [NUM_STALL_SRC-1:0] wr_gate,
  output logic [NUM_STALL_SRC-1:0] stall_owner,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              instret
);

  PipeCtrlState             state_q;
  logic [NUM_STALL_SRC-1:0] owner_q;
  logic [NUM_STALL_SRC-1:0] grant_c;
  logic [NUM_STAGES-1:1]    vld_q;
  logic [31:0]              stall_cycles_q, stall_cycles_d;
  logic [31:0]              instret_q, instret_d;
  logic                     any_req_c;

  stall_arbiter #(.NUM_STALL_SRC(NUM_STALL_SRC)) u_arb (
    .req_i   (stall_req),
    .owner_i (owner_q),
    .state_i (state_q),
    .grant_o (grant_c)
  );

  assign any_req_c = |stall_req;
  assign stall     = any_req_c;
  assign pc_en     = ~stall & ~insert_nop;
  assign bubble_id = ~stall & (insert_nop | branch_redo);
  assign wr_gate   = any_req_c ? grant_c : '1;

  // Fetch always holds a live instruction once out of reset.
  assign stage_valid = {vld_q, reset_n};
  assign stall_owner = owner_q;

  // A request pending on the cycle the owner drops hands over directly, no RUN gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PIPE_RUN;
      owner_q <= '0;
    end else begin
      case (state_q)
        PIPE_RUN: begin
          if (any_req_c) begin
            state_q <= PIPE_STALL;
            owner_q <= grant_c;
          end
        end
        PIPE_STALL: begin
          if (any_req_c) begin
            owner_q <= grant_c;
          end else begin
            state_q <= PIPE_RUN;
            owner_q <= '0;
          end
        end
        default: begin
          state_q <= PIPE_RUN;
          owner_q <= '0;
        end
      endcase
    end
  end

  assign stall_cycles_d = (stall && stall_cycles_q != 32'hFFFF_FFFF) ? stall_cycles_q + 32'd1
                                                                      : stall_cycles_q;
  assign instret_d      = (!stall && vld_q[NUM_STAGES-1]) ? instret_q + 32'd1 : instret_q;

  // Stall freezes everything; a hazard seen under stall is simply re-sampled later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q          <= '0;
      stall_cycles_q <= '0;
      instret_q      <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      instret_q      <= instret_d;
      if (!stall) begin
        vld_q[STAGE_ID] <= ~(insert_nop | branch_redo);
        for (int i = STAGE_ID + 1; i < NUM_STAGES; i++) vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller (5 stages, 2 stall sources).
module tb_pipeline_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] stall_req;
  logic       insert_nop, branch_redo;
  logic       stall, pc_en, bubble_id;
  logic [4:0] stage_valid;
  logic [1:0] wr_gate, stall_owner;
  logic [31:0] stall_cycles, instret;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_controller #(.NUM_STAGES(5), .NUM_STALL_SRC(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall_req    (stall_req),
    .insert_nop   (insert_nop),
    .branch_redo  (branch_redo),
    .stall        (stall),
    .pc_en        (pc_en),
    .bubble_id    (bubble_id),
    .stage_valid  (stage_valid),
    .wr_gate      (wr_gate),
    .stall_owner  (stall_owner),
    .stall_cycles (stall_cycles),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall_req = 2'b00; insert_nop = 1'b0; branch_redo = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall_req = 2'b00; insert_nop = 1'b0; branch_redo = 1'b0;
    #2;
    n_checks++; if (stage_valid !== 5'b00000) begin n_fail++; $display("FAIL reset_valid got=%b exp=00000", stage_valid); end
    n_checks++; if (stall_owner !== 2'b00) begin n_fail++; $display("FAIL reset_owner got=%b exp=00", stall_owner); end
    n_checks++; if (stall_cycles !== 32'd0 || instret !== 32'd0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, instret); end
    n_checks++; if ({stall, pc_en, bubble_id, wr_gate} !== 5'b01011) begin n_fail++; $display("FAIL reset_comb got=%b exp=01011", {stall, pc_en, bubble_id, wr_gate}); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_no_stalls();
    logic [4:0] exp;
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp = (c >= 4) ? 5'b11111 : 5'((1 << (c + 1)) - 1);
      n_checks++; if (stage_valid !== exp) begin n_fail++; $display("FAIL fill_valid c=%0d got=%b exp=%b", c, stage_valid, exp); end
    end
    n_checks++; if (instret !== 32'd6) begin n_fail++; $display("FAIL fill_instret got=%0d exp=6", instret); end
  endtask

  task automatic test_stall_single();
    do_reset();
    fill(6);                                   // instret = 2
    stall_req = 2'b01;
    #1;
    n_checks++; if ({stall, pc_en, bubble_id, wr_gate} !== 5'b10001) begin n_fail++; $display("FAIL s1_comb got=%b exp=10001", {stall, pc_en, bubble_id, wr_gate}); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++; if (stall_owner !== 2'b01 || wr_gate !== 2'b01) begin n_fail++; $display("FAIL s1_owner c=%0d got=%b/%b exp=01/01", c, stall_owner, wr_gate); end
      n_checks++; if (stage_valid !== 5'b11111 || instret !== 32'd2) begin n_fail++; $display("FAIL s1_hold c=%0d got=%b/%0d exp=11111/2", c, stage_valid, instret); end
    end
    n_checks++; if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL s1_cycles got=%0d exp=3", stall_cycles); end
    stall_req = 2'b00;
    #1;
    n_checks++; if (stall !== 1'b0 || wr_gate !== 2'b11) begin n_fail++; $display("FAIL s1_release got=%b/%b exp=0/11", stall, wr_gate); end
    tick();
    n_checks++; if (stall_owner !== 2'b00 || stall_cycles !== 32'd3 || instret !== 32'd3) begin n_fail++; $display("FAIL s1_after got=%b/%0d/%0d exp=00/3/3", stall_owner, stall_cycles, instret); end
  endtask

  task automatic test_stall_switch();
    do_reset();
    fill(5);
    stall_req = 2'b11;
    #1;
    n_checks++; if (wr_gate !== 2'b10) begin n_fail++; $display("FAIL sw_grant0 got=%b exp=10", wr_gate); end
    tick();
    n_checks++; if (stall_owner !== 2'b10 || wr_gate !== 2'b10) begin n_fail++; $display("FAIL sw_owner1 got=%b/%b exp=10/10", stall_owner, wr_gate); end
    tick();
    n_checks++; if (stall_owner !== 2'b10) begin n_fail++; $display("FAIL sw_owner2 got=%b exp=10", stall_owner); end
    stall_req = 2'b01;
    #1;
    n_checks++; if (stall !== 1'b1 || wr_gate !== 2'b01) begin n_fail++; $display("FAIL sw_handover got=%b/%b exp=1/01", stall, wr_gate); end
    tick();
    n_checks++; if (stall_owner !== 2'b01 || wr_gate !== 2'b01) begin n_fail++; $display("FAIL sw_owner3 got=%b/%b exp=01/01", stall_owner, wr_gate); end
    stall_req = 2'b11;                         // higher source must not preempt a holding owner
    #1;
    n_checks++; if (wr_gate !== 2'b01) begin n_fail++; $display("FAIL sw_hold got=%b exp=01", wr_gate); end
    stall_req = 2'b00;
    tick();
    n_checks++; if (stall_owner !== 2'b00 || stall_cycles !== 32'd3 || stage_valid !== 5'b11111) begin n_fail++; $display("FAIL sw_end got=%b/%0d/%b exp=00/3/11111", stall_owner, stall_cycles, stage_valid); end
  endtask

  task automatic test_insert_nop();
    logic [4:0] exp_v [1:4];
    exp_v[1] = 5'b11101; exp_v[2] = 5'b11011; exp_v[3] = 5'b10111; exp_v[4] = 5'b01111;
    do_reset();
    fill(5);                                   // instret = 1
    insert_nop = 1'b1;
    #1;
    n_checks++; if ({stall, pc_en, bubble_id} !== 3'b001) begin n_fail++; $display("FAIL nop_comb got=%b exp=001", {stall, pc_en, bubble_id}); end
    tick();
    insert_nop = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      n_checks++; if (stage_valid !== exp_v[c]) begin n_fail++; $display("FAIL nop_hole c=%0d got=%b exp=%b", c, stage_valid, exp_v[c]); end
    end
    tick();
    n_checks++; if (instret !== 32'd5) begin n_fail++; $display("FAIL nop_instret got=%0d exp=5", instret); end
    branch_redo = 1'b1;
    #1;
    n_checks++; if ({pc_en, bubble_id} !== 2'b11) begin n_fail++; $display("FAIL redo_comb got=%b exp=11", {pc_en, bubble_id}); end
    tick();
    branch_redo = 1'b0;
    n_checks++; if (stage_valid[1] !== 1'b0) begin n_fail++; $display("FAIL redo_squash got=%b exp=0", stage_valid[1]); end
  endtask

  task automatic test_nop_under_stall();
    do_reset();
    fill(5);
    stall_req = 2'b01; insert_nop = 1'b1;
    #1;
    n_checks++; if ({stall, pc_en, bubble_id} !== 3'b100) begin n_fail++; $display("FAIL ns_comb got=%b exp=100", {stall, pc_en, bubble_id}); end
    tick();
    tick();
    n_checks++; if (stage_valid !== 5'b11111) begin n_fail++; $display("FAIL ns_hold got=%b exp=11111", stage_valid); end
    stall_req = 2'b00;
    #1;
    n_checks++; if ({stall, pc_en, bubble_id} !== 3'b001) begin n_fail++; $display("FAIL ns_release got=%b exp=001", {stall, pc_en, bubble_id}); end
    tick();
    insert_nop = 1'b0;
    n_checks++; if (stage_valid !== 5'b11101) begin n_fail++; $display("FAIL ns_bubble got=%b exp=11101", stage_valid); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    fill(5);
    stall_req = 2'b10;
    tick();
    tick();
    n_checks++; if (stall_owner !== 2'b10 || stall_cycles !== 32'd2) begin n_fail++; $display("FAIL rm_pre got=%b/%0d exp=10/2", stall_owner, stall_cycles); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (stall_owner !== 2'b00 || stall_cycles !== 32'd0 || instret !== 32'd0) begin n_fail++; $display("FAIL rm_async got=%b/%0d/%0d exp=00/0/0", stall_owner, stall_cycles, instret); end
    n_checks++; if (stage_valid !== 5'b00000) begin n_fail++; $display("FAIL rm_valid got=%b exp=00000", stage_valid); end
    stall_req = 2'b00;
    #1 reset_n = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0 || wr_gate !== 2'b11) begin n_fail++; $display("FAIL rm_free got=%b/%b exp=0/11", stall, wr_gate); end
    stall_req = 2'b01;
    #1;
    n_checks++; if (stall !== 1'b1 || wr_gate !== 2'b01) begin n_fail++; $display("FAIL rm_restall got=%b/%b exp=1/01", stall, wr_gate); end
    tick();
    n_checks++; if (stall_owner !== 2'b01) begin n_fail++; $display("FAIL rm_newowner got=%b exp=01", stall_owner); end
    stall_req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_no_stalls();
    test_stall_single();
    test_stall_switch();
    test_insert_nop();
    test_nop_under_stall();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
